// File: rtl/rc6_pkg.sv
// -----------------------------------------------------------------------------
// rc6_pkg
// Shared constants and helpers for the RC6-32/20/b key schedule and datapath.
//   RC6_W / RC6_R / RC6_T : word width, round count, round-key table size
//   RC6_P32 / RC6_Q32     : magic constants used to seed the key table
//   ST_*                  : state encodings for the key-schedule FSM
//   rc6_init_word()       : P32 + idx*Q32, the seed value of S[idx]
//   rc6_rol3()            : fixed rotate-left by 3 (pure wiring)
// -----------------------------------------------------------------------------
package rc6_pkg;

  localparam int RC6_W = 32;
  localparam int RC6_R = 20;
  localparam int RC6_T = 2 * RC6_R + 4;

  localparam logic [RC6_W-1:0] RC6_P32 = 32'hB7E1_5163;
  localparam logic [RC6_W-1:0] RC6_Q32 = 32'h9E37_79B9;

  // Every mixing pass visits 3*max(T, c) words; c is at most 8, so T dominates.
  localparam int RC6_MIX_STEPS = 3 * RC6_T;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_MIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    INIT = ST_INIT,
    MIX  = ST_MIX,
    DONE = ST_DONE
  } ks_state_e;

  function automatic logic [RC6_W-1:0] rc6_init_word(input int idx);
    return RC6_P32 + RC6_Q32 * RC6_W'(idx);
  endfunction

  function automatic logic [RC6_W-1:0] rc6_rol3(input logic [RC6_W-1:0] x);
    return {x[RC6_W-4:0], x[RC6_W-1:RC6_W-3]};
  endfunction

endpackage

// File: rtl/rc6_rol.sv
// -----------------------------------------------------------------------------
// rc6_rol
// Combinational 32-bit rotate-left by a variable amount.
//   din  : word to rotate
//   amt  : rotate amount, 0..31
//   dout : din rotated left by amt
// -----------------------------------------------------------------------------
module rc6_rol
  import rc6_pkg::*;
(
  input  logic [RC6_W-1:0] din,
  input  logic [4:0]       amt,
  output logic [RC6_W-1:0] dout
);

  // A right shift by 32 (amt = 0) yields zero, so the OR leaves din intact.
  assign dout = (din << amt) | (din >> (6'd32 - {1'b0, amt}));

endmodule

// File: rtl/rc6_keysched.sv
// -----------------------------------------------------------------------------
// rc6_keysched
// RC6-32/20/b key expansion: turns a user key into the 44-word round-key table
// S[0..43], one mixing step per clock, and holds the table until the next load.
//
// Parameters
//   KEY_BYTES    : user-key length in bytes (16, 24 or 32)
// Ports
//   i_clk        : clock
//   i_rst        : synchronous reset, active-high (wins over i_key_en)
//   i_key        : user key, byte k at i_key[8k+7:8k]
//   i_key_en     : 1-cycle start strobe, i_key sampled on the same edge
//   o_keyex      : key table, S[i] = o_keyex[32*(44-i)-1 -: 32]
//   o_keyex_vld  : high while o_keyex holds a complete table
//   o_busy       : high from the edge after start until the table is complete
//   o_done       : 1-cycle pulse when o_keyex_vld first rises
//
// Configuration
//   RC6_KEYSCHED_FAST_INIT_EN : when defined, the whole S table is seeded with
//   P32+i*Q32 on the start edge and INIT is skipped (133-edge latency instead
//   of 177, at the cost of 44 parallel constant loads).
// -----------------------------------------------------------------------------
module rc6_keysched
  import rc6_pkg::*;
#(
  parameter int KEY_BYTES = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [8*KEY_BYTES-1:0]   i_key,
  input  logic                     i_key_en,
  output logic [RC6_W*RC6_T-1:0]   o_keyex,
  output logic                     o_keyex_vld,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int C = KEY_BYTES / 4;

  generate
    if (KEY_BYTES != 16 && KEY_BYTES != 24 && KEY_BYTES != 32) begin : g_bad_key_bytes
      $error("rc6_keysched: KEY_BYTES must be 16, 24 or 32");
    end
  endgenerate

  ks_state_e        state;
  logic [RC6_W-1:0] s [RC6_T];
  logic [RC6_W-1:0] l [8];
  logic [RC6_W-1:0] a;
  logic [RC6_W-1:0] b;
  logic [5:0]       i;
  logic [2:0]       j;
  logic [7:0]       k;
  logic             vld;
  logic             busy;
  logic             done;
`ifndef RC6_KEYSCHED_FAST_INIT_EN
  logic [RC6_W-1:0] init_word;   // running P32 + i*Q32
`endif

  // One mixing step, fully combinational from the current registers.
  logic [RC6_W-1:0] a_new;
  logic [RC6_W-1:0] ab_sum;
  logic [RC6_W-1:0] lb_sum;
  logic [RC6_W-1:0] b_new;

  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later lines see earlier
    // results within the same evaluation; clocked state below uses '<='.
    a_new  = rc6_rol3(s[i] + a + b);
    ab_sum = a_new + b;
    lb_sum = l[j] + ab_sum;
  end

  rc6_rol u_rol_b (
    .din  (lb_sum),
    .amt  (ab_sum[4:0]),
    .dout (b_new)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: S and L are plain flop arrays, so they can be (and are) cleared
      // on reset; a RAM-mapped array could not be cleared this way.
      for (int n = 0; n < RC6_T; n++) s[n] <= '0;
      for (int n = 0; n < 8; n++)     l[n] <= '0;
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      vld   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifndef RC6_KEYSCHED_FAST_INIT_EN
      init_word <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (i_key_en) begin
            for (int n = 0; n < C; n++) l[n] <= i_key[RC6_W*n +: RC6_W];
            for (int n = C; n < 8; n++) l[n] <= '0;
            a    <= '0;
            b    <= '0;
            i    <= '0;
            j    <= '0;
            k    <= '0;
            vld  <= 1'b0;
            busy <= 1'b1;
`ifdef RC6_KEYSCHED_FAST_INIT_EN
            for (int n = 0; n < RC6_T; n++) s[n] <= rc6_init_word(n);
            state <= MIX;
`else
            init_word <= RC6_P32;
            state     <= INIT;
`endif
          end
        end

`ifndef RC6_KEYSCHED_FAST_INIT_EN
        INIT: begin
          s[i]      <= init_word;
          init_word <= init_word + RC6_Q32;
          if (i == 6'(RC6_T - 1)) begin
            i     <= '0;
            state <= MIX;
          end else begin
            i <= i + 6'd1;
          end
        end
`endif

        MIX: begin
          s[i] <= a_new;
          l[j] <= b_new;
          a    <= a_new;
          b    <= b_new;
          i    <= (i == 6'(RC6_T - 1)) ? 6'd0 : i + 6'd1;
          j    <= (j == 3'(C - 1))     ? 3'd0 : j + 3'd1;
          k    <= k + 8'd1;
          if (k == 8'(RC6_MIX_STEPS - 1)) begin
            vld   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    o_keyex = '0;
    for (int n = 0; n < RC6_T; n++) o_keyex[RC6_W*(RC6_T-n)-1 -: RC6_W] = s[n];
  end

  assign o_keyex_vld = vld;
  assign o_busy      = busy;
  assign o_done      = done;

endmodule

// File: tb/tb_rc6_keysched.sv
// -----------------------------------------------------------------------------
// tb_rc6_keysched
// Self-checking bench for rc6_keysched. Three instances (16/24/32-byte keys)
// share clock and reset. Expected key tables come from a behavioural model of
// the RC6 key schedule and are queued at start, then popped on o_done. An RC6
// encryption model checks the zero-key table against the published ciphertext.
// Honours RC6_KEYSCHED_FAST_INIT_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_rc6_keysched;

  localparam int T  = 44;
  localparam int TW = 32 * T;
  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;
`ifdef RC6_KEYSCHED_FAST_INIT_EN
  localparam int LAT  = 133;
  localparam int MIX0 = 2;
`else
  localparam int LAT  = 177;
  localparam int MIX0 = 46;
`endif
  localparam int BUDGET = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic [255:0]  key;
  logic [2:0]    key_en;
  logic [TW-1:0] keyex0, keyex1, keyex2;
  logic [2:0]    vld, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [TW-1:0] exp_q[$];

  always #5 clk = ~clk;

  rc6_keysched #(.KEY_BYTES(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_key(key[127:0]), .i_key_en(key_en[0]),
    .o_keyex(keyex0), .o_keyex_vld(vld[0]), .o_busy(busy[0]), .o_done(done[0]));

  rc6_keysched #(.KEY_BYTES(24)) dut24 (
    .i_clk(clk), .i_rst(rst), .i_key(key[191:0]), .i_key_en(key_en[1]),
    .o_keyex(keyex1), .o_keyex_vld(vld[1]), .o_busy(busy[1]), .o_done(done[1]));

  rc6_keysched #(.KEY_BYTES(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_key(key[255:0]), .i_key_en(key_en[2]),
    .o_keyex(keyex2), .o_keyex_vld(vld[2]), .o_busy(busy[2]), .o_done(done[2]));

  function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    return (x << m) | (x >> (32 - m));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Reference key schedule, written straight from the algorithm.
  function automatic logic [TW-1:0] model(input logic [255:0] kk, input int nbytes);
    logic [31:0] sw [T];
    logic [31:0] lw [8];
    logic [31:0] ra, rb;
    logic [TW-1:0] r;
    int c, ii, jj;
    c  = nbytes / 4;
    ii = 0;
    jj = 0;
    for (int w = 0; w < c; w++) lw[w] = kk[32*w +: 32];
    sw[0] = P32;
    for (int n = 1; n < T; n++) sw[n] = sw[n-1] + Q32;
    ra = 0;
    rb = 0;
    for (int st = 0; st < 3 * T; st++) begin
      ra = rol32(sw[ii] + ra + rb, 3);
      sw[ii] = ra;
      rb = rol32(lw[jj] + ra + rb, int'((ra + rb) & 32'd31));
      lw[jj] = rb;
      ii = (ii + 1) % T;
      jj = (jj + 1) % c;
    end
    for (int n = 0; n < T; n++) r[32*(T-n)-1 -: 32] = sw[n];
    return r;
  endfunction

  // RC6 encryption of an all-zero block; returns ciphertext byte 0 in the MSBs.
  function automatic logic [127:0] encrypt_zero(input logic [TW-1:0] tab);
    logic [31:0] sk [T];
    logic [31:0] ra, rb, rc, rd, t, u, tmp;
    for (int n = 0; n < T; n++) sk[n] = tab[32*(T-n)-1 -: 32];
    ra = 0; rb = 0; rc = 0; rd = 0;
    rb = rb + sk[0];
    rd = rd + sk[1];
    for (int rr = 1; rr <= 20; rr++) begin
      t   = rol32(rb * (2 * rb + 32'd1), 5);
      u   = rol32(rd * (2 * rd + 32'd1), 5);
      ra  = rol32(ra ^ t, int'(u[4:0])) + sk[2*rr];
      rc  = rol32(rc ^ u, int'(t[4:0])) + sk[2*rr+1];
      tmp = ra; ra = rb; rb = rc; rc = rd; rd = tmp;
    end
    ra = ra + sk[42];
    rc = rc + sk[43];
    return {bswap(ra), bswap(rb), bswap(rc), bswap(rd)};
  endfunction

  function automatic logic [TW-1:0] get_tab(input int sel);
    case (sel)
      0:       return keyex0;
      1:       return keyex1;
      default: return keyex2;
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_tab(input string name, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    int idx;
    idx = 0;
    for (int n = T - 1; n >= 0; n--)
      if (obs[32*(T-n)-1 -: 32] !== exp[32*(T-n)-1 -: 32]) idx = n;
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: S[%0d] observed %08h expected %08h", name, idx,
             obs[32*(T-idx)-1 -: 32], exp[32*(T-idx)-1 -: 32]);
    end
  endtask

  // Start one key expansion on instance sel and follow it to completion.
  // poke_edge: edge (start = 1) on which a second start strobe is sampled.
  // abort_edge: edge on which reset is sampled instead of completing.
  task automatic run(input int sel, input logic [255:0] k, input int nbytes,
                     input int poke_edge, input int abort_edge, input string name);
    int  edge_n;
    bit  seen;
    @(negedge clk);
    key         = k;
    key_en[sel] = 1'b1;
    exp_q.push_back(model(k, nbytes));
    @(posedge clk);
    @(negedge clk);
    key_en[sel] = 1'b0;
    key         = ~k;
    check({name, " vld on start"},  vld[sel],  1'b0);
    check({name, " busy on start"}, busy[sel], 1'b1);
    edge_n = 1;
    seen   = 1'b0;
    while (!seen && edge_n < BUDGET) begin
      if (edge_n + 1 == poke_edge)  key_en[sel] = 1'b1;
      if (edge_n + 1 == abort_edge) rst = 1'b1;
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      key_en[sel] = 1'b0;
      if (edge_n == abort_edge) begin
        rst = 1'b0;
        check({name, " busy after rst"}, busy[sel], 1'b0);
        check({name, " vld after rst"},  vld[sel],  1'b0);
        check({name, " done after rst"}, done[sel], 1'b0);
        check_tab({name, " table after rst"}, get_tab(sel), '0);
        void'(exp_q.pop_front());
        return;
      end
      if (done[sel]) seen = 1'b1;
    end
    check({name, " done edge"}, edge_n, LAT);
    check({name, " vld at done"},  vld[sel],  1'b1);
    check({name, " busy at done"}, busy[sel], 1'b0);
    if (exp_q.size() != 0) check_tab({name, " table"}, get_tab(sel), exp_q.pop_front());
    @(negedge clk);
    check({name, " done one cycle"}, done[sel], 1'b0);
    check({name, " vld held"},       vld[sel],  1'b1);
  endtask

  initial begin
    logic [255:0] rk;
    logic [TW-1:0] tab;

    // 1: reset then idle
    rst    = 1'b1;
    key    = '0;
    key_en = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    for (int sel = 0; sel < 3; sel++) begin
      check($sformatf("reset vld%0d", sel),  vld[sel],  1'b0);
      check($sformatf("reset busy%0d", sel), busy[sel], 1'b0);
      check($sformatf("reset done%0d", sel), done[sel], 1'b0);
      check_tab($sformatf("reset table%0d", sel), get_tab(sel), '0);
    end

    // 2 + 3: zero 128-bit key, then end-to-end encryption of a zero block
    run(0, '0, 16, 0, 0, "zero16");
    tab = get_tab(0);
    check("zero16 ciphertext", encrypt_zero(tab), 128'h8fc3a53656b1f778c129df4e9848a41e);
    repeat (5) @(negedge clk);
    check_tab("zero16 table held", get_tab(0), model('0, 16));

    // 4: random keys back-to-back for each key length
    for (int sel = 0; sel < 3; sel++) begin
      for (int r = 0; r < 2; r++) begin
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run(sel, rk, 16 + 8 * sel, 0, 0, $sformatf("rand kb%0d #%0d", 16 + 8 * sel, r));
      end
    end

    // 5: second start strobe on edge 50 is ignored
    rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run(0, rk, 16, 50, 0, "poke50");

    // 6: reset at MIX step 60, then a fresh run with key 00..0F
    rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run(0, rk, 16, 0, MIX0 + 60, "abort");
    run(0, 256'h0f0e0d0c0b0a09080706050403020100, 16, 0, 0, "after abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
